mem_ctrl_arb: RTL and testbench
===============================

Name: mem_ctrl_arb

Overview:
- Parametrised byte-serial memory controller for the CPU's 8-bit RAM/IO bus.
- Arbitrates NUM_PORTS independent requesters (ifetch, LSB, future D-cache refill, etc.) with round-robin priority.
- Moves 1..MAX_BYTES bytes per transaction, little-endian.
- Adds per-port rollback kill, signed/unsigned load extension and IO-full store stall.

Parameters:
- NUM_PORTS, 2, number of requester channels; 1..8.
- ADDR_W, 32, address width; mem_a is 32 bits, zero-extended.
- MAX_BYTES, 4, maximum transfer size in bytes; power of 2, 1..8.
- LEN_W, 4, width of a length field; must hold MAX_BYTES.
- KILL_MASK, 2'b10, bit p=1 means a port-p load is cancelled by rollback.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global enable; 0 freezes the block.
- rollback  in  1  pipeline flush.
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  RAM read data; valid one cycle after mem_a.
- mem_dout  out  8  write data.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- req_en  in  NUM_PORTS  per-port request, held until done.
- req_wr  in  NUM_PORTS  1 = store.
- req_sext  in  NUM_PORTS  1 = sign-extend load result.
- req_addr  in  NUM_PORTS*ADDR_W  start address, port p at [p*ADDR_W +: ADDR_W].
- req_len  in  NUM_PORTS*LEN_W  byte count, 1..MAX_BYTES.
- req_wdata  in  NUM_PORTS*8*MAX_BYTES  store data, byte 0 at LSBs.
- done  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- rdata  out  8*MAX_BYTES  load result; valid while any done bit is high.

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE, done=0, mem_wr=0, mem_a=0, mem_dout=0, rdata=0.
  - rr_ptr=0; cnt=0.
  - Reset mid-transaction abandons it silently; no done pulse.
- rdy=0: all state, cnt and rdata are held; mem_wr<=0 and mem_a is held. On rdy returning to 1 the current byte is re-issued.
- States: IDLE, GAP, LOAD, STORE.
- IDLE:
  - Candidates are ports with req_en=1.
  - If rollback=1, candidates whose port is in KILL_MASK and whose req_wr=0 are excluded that cycle.
  - Grant goes to the first candidate at or after rr_ptr, modulo NUM_PORTS.
  - On grant: latch port id g, addr, len, wdata and sext; set rr_ptr=(g+1) mod NUM_PORTS; cnt=0.
  - Load grant: mem_a<=addr, state LOAD.
  - Store grant: state STORE.
- LOAD, grant at edge T:
  - Byte i is addressed on edge T+i and captured from mem_din on edge T+1+i.
  - mem_a increments each edge; mem_a is forced to 0 on the edge that addresses no further byte.
  - At edge T+len, after capturing the last byte: upper bytes are filled with the sign of byte len-1 if sext=1, else 0.
  - At that edge: rdata is written, done[g]<=1, state GAP.
  - Load latency: done visible len cycles after the grant edge.
- STORE, grant at edge T:
  - If addr[17:16]==2'b11 and io_buffer_full=1, the edge stalls with no progress and mem_wr=0.
  - Otherwise, at edge T+1+i: mem_wr<=1, mem_a<=addr+i, mem_dout<=wdata byte i.
  - The edge after the last byte: mem_wr<=0, mem_a<=0, done[g]<=1, state GAP.
  - Store with no stalls: done visible len+1 cycles after the grant edge.
  - Stores are never cancelled by rollback.
- LOAD with rollback=1 and g in KILL_MASK: abort at that edge. mem_a<=0, state IDLE, no done pulse, rdata unchanged. Ports not in KILL_MASK ignore rollback.
- GAP: done<=0, mem_wr<=0; exactly one cycle, then IDLE. Requester must drop or change req_en in the done cycle.
- len=0 or len>MAX_BYTES: treated as MAX_BYTES.
- Address arithmetic wraps modulo 2^32.
- done is never asserted for two ports in the same cycle.

Test Plan:
- Port 1 loads len=4 at 0x100, RAM bytes 11,22,33,44 → mem_a sequence 0x100..0x103; done[1] 4 cycles after grant; rdata=0x44332211.
- Port 1 loads len=1, sext=1, byte 0x80 → rdata=0xFFFFFF80; the same load with sext=0 → 0x00000080.
- Port 1 stores len=2 of 0xBEEF to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 during the stall; then writes EF@0x30000, BE@0x30001; done[1] once.
- Ports 0 and 1 both requesting continuously → grants alternate 0,1,0,1; each done is followed by a GAP cycle.
- Port 1 load len=4 with rollback pulsed after 2 bytes → no done; next grant is port 0. A port-0 load under rollback completes normally.
- rst=0 mid-store and rdy=0 for 5 cycles mid-load → reset: all outputs zero and idle. rdy pause: the mem_a value is held, then the load completes with correct rdata.

Source files
------------

// File: rtl/mem_ctrl_arb.sv
// Round-robin byte-serial memory controller for the CPU's 8-bit RAM/IO bus.
// Each granted request moves 1..MAX_BYTES little-endian bytes; loads may be killed by rollback.
module mem_ctrl_arb #(
    parameter int                   NUM_PORTS = 2,
    parameter int                   ADDR_W    = 32,
    parameter int                   MAX_BYTES = 4,
    parameter int                   LEN_W     = 4,
    parameter logic [NUM_PORTS-1:0] KILL_MASK = NUM_PORTS'(2'b10)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           rollback,
    input  logic                           io_buffer_full,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [31:0]                    mem_a,
    output logic                           mem_wr,
    input  logic [NUM_PORTS-1:0]           req_en,
    input  logic [NUM_PORTS-1:0]           req_wr,
    input  logic [NUM_PORTS-1:0]           req_sext,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]     req_len,
    input  logic [NUM_PORTS*8*MAX_BYTES-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           done,
    output logic [8*MAX_BYTES-1:0]         rdata
);

    localparam int               PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int               DATA_W  = 8 * MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, GAP, LOAD, STORE} state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]    port_reg, port_next;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                sext_reg, sext_next;
    logic [DATA_W-1:0]   ld_buf_reg, ld_buf_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [NUM_PORTS-1:0] done_reg, done_next;
    logic                mem_wr_reg, mem_wr_next;
    logic [31:0]         mem_a_reg, mem_a_next;
    logic [7:0]          mem_dout_reg, mem_dout_next;

    logic [ADDR_W-1:0]   port_addr  [NUM_PORTS];
    logic [LEN_W-1:0]    port_len   [NUM_PORTS];
    logic [DATA_W-1:0]   port_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand;

    logic                grant_valid;
    logic [PTR_W-1:0]    grant_id;
    logic [DATA_W-1:0]   ld_capture, ld_final;
    logic [7:0]          st_byte;
    logic [NUM_PORTS-1:0] done_onehot;
    logic                io_stall;

    // A killable load is hidden from arbitration while rollback is high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign port_len[gi]   = req_len[gi*LEN_W +: LEN_W];
            assign port_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign cand[gi]       = req_en[gi] & ~(rollback & KILL_MASK[gi] & ~req_wr[gi]);
        end
    endgenerate

    function automatic logic [31:0] bus_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] r;
        r = '0;
        r[ADDR_W-1:0] = a;
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] offs(input logic [LEN_W-1:0] c);
        logic [ADDR_W-1:0] r;
        r = '0;
        r[LEN_W-1:0] = c;
        return r;
    endfunction

    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
        if (l == '0 || l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    // Scan downward so the closest candidate at or after rr_ptr wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (cand[idx]) begin
                grant_valid = 1'b1;
                grant_id    = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        ld_capture  = ld_buf_reg;
        ld_final    = '0;
        st_byte     = '0;
        done_onehot = '0;
        done_onehot[port_reg] = 1'b1;
        for (int j = 0; j < MAX_BYTES; j++) begin
            if (j == int'(cnt_reg)) begin
                ld_capture[j*8 +: 8] = mem_din;
                st_byte              = wdata_reg[j*8 +: 8];
            end
        end
        // The byte captured on the final edge is byte len-1, so its MSB is the sign.
        for (int j = 0; j < MAX_BYTES; j++) begin
            if (j < int'(len_reg)) ld_final[j*8 +: 8] = ld_capture[j*8 +: 8];
            else                   ld_final[j*8 +: 8] = {8{sext_reg & mem_din[7]}};
        end
    end

    assign io_stall = (addr_reg[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        port_next     = port_reg;
        cnt_next      = cnt_reg;
        len_next      = len_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        sext_next     = sext_reg;
        ld_buf_next   = ld_buf_reg;
        rdata_next    = rdata_reg;
        done_next     = done_reg;
        mem_wr_next   = mem_wr_reg;
        mem_a_next    = mem_a_reg;
        mem_dout_next = mem_dout_reg;
        if (!rdy) begin
            mem_wr_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        port_next   = grant_id;
                        addr_next   = port_addr[grant_id];
                        len_next    = norm_len(port_len[grant_id]);
                        wdata_next  = port_wdata[grant_id];
                        sext_next   = req_sext[grant_id];
                        rr_ptr_next = (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + PTR_W'(1);
                        cnt_next    = '0;
                        if (req_wr[grant_id]) begin
                            state_next = STORE;
                        end else begin
                            state_next  = LOAD;
                            mem_a_next  = bus_addr(port_addr[grant_id]);
                            ld_buf_next = '0;
                        end
                    end
                end
                LOAD: begin
                    if (rollback && KILL_MASK[port_reg]) begin
                        mem_a_next = '0;
                        state_next = IDLE;
                    end else begin
                        ld_buf_next = ld_capture;
                        if (cnt_reg == len_reg - LEN_W'(1)) begin
                            rdata_next = ld_final;
                            done_next  = done_onehot;
                            mem_a_next = '0;
                            state_next = GAP;
                        end else begin
                            cnt_next   = cnt_reg + LEN_W'(1);
                            mem_a_next = bus_addr(addr_reg + offs(cnt_reg + LEN_W'(1)));
                        end
                    end
                end
                STORE: begin
                    if (cnt_reg == len_reg) begin
                        mem_wr_next = 1'b0;
                        mem_a_next  = '0;
                        done_next   = done_onehot;
                        state_next  = GAP;
                    end else if (io_stall) begin
                        mem_wr_next = 1'b0;
                    end else begin
                        mem_wr_next   = 1'b1;
                        mem_a_next    = bus_addr(addr_reg + offs(cnt_reg));
                        mem_dout_next = st_byte;
                        cnt_next      = cnt_reg + LEN_W'(1);
                    end
                end
                GAP: begin
                    done_next   = '0;
                    mem_wr_next = 1'b0;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            port_reg     <= '0;
            cnt_reg      <= '0;
            len_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            sext_reg     <= 1'b0;
            ld_buf_reg   <= '0;
            rdata_reg    <= '0;
            done_reg     <= '0;
            mem_wr_reg   <= 1'b0;
            mem_a_reg    <= '0;
            mem_dout_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            port_reg     <= port_next;
            cnt_reg      <= cnt_next;
            len_reg      <= len_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            sext_reg     <= sext_next;
            ld_buf_reg   <= ld_buf_next;
            rdata_reg    <= rdata_next;
            done_reg     <= done_next;
            mem_wr_reg   <= mem_wr_next;
            mem_a_reg    <= mem_a_next;
            mem_dout_reg <= mem_dout_next;
        end
    end

    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign mem_wr   = mem_wr_reg;
    assign mem_a    = mem_a_reg;
    assign mem_dout = mem_dout_reg;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: directed vector table, multi-cycle corner sequences and
// randomized single-port transactions checked against a transaction-level model.
module tb_mem_ctrl_arb;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int MB = 4;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst, rdy, rollback, io_buffer_full;
    logic [7:0]        mem_din, mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;
    logic [NP-1:0]     req_en, req_wr, req_sext, done;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*LW-1:0]  req_len;
    logic [NP*8*MB-1:0] req_wdata;
    logic [8*MB-1:0]   rdata;

    logic [7:0]  rom [0:65535];
    logic [39:0] wr_log [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rdata;

    typedef struct {
        int          port;
        bit          wr;
        bit          sext;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;
    assign mem_din = rom[mem_a[15:0]];
    always @(posedge clk) if (mem_wr) wr_log.push_back({mem_a, mem_dout});

    mem_ctrl_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(MB), .LEN_W(LW), .KILL_MASK(2'b10)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .req_en(req_en), .req_wr(req_wr), .req_sext(req_sext), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .done(done), .rdata(rdata)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for done", name);
    endtask

    function automatic int eff_len(input logic [3:0] l);
        if (l == 4'd0 || l > 4'd4) return MB;
        return int'(l);
    endfunction

    // Little-endian assembly from memory, then sign/zero fill above byte n-1.
    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sx);
        logic [63:0] r;
        logic [31:0] ai;
        bit          neg;
        r   = '0;
        neg = 1'b0;
        for (int i = 0; i < n; i++) begin
            ai  = a + 32'(i);
            r   = r | (64'(rom[ai[15:0]]) << (8 * i));
            neg = rom[ai[15:0]][7];
        end
        if (sx && neg) r = r | ~((64'd1 << (8 * n)) - 64'd1);
        return r[31:0];
    endfunction

    task automatic set_port(input int p, input bit wr, input bit sx, input logic [31:0] a,
                            input logic [3:0] l, input logic [31:0] wd);
        req_wr[p]               = wr;
        req_sext[p]             = sx;
        req_addr[p*AW +: AW]    = a;
        req_len[p*LW +: LW]     = l;
        req_wdata[p*8*MB +: 32] = wd;
    endtask

    // Runs one request on an idle controller; called and returns at a negedge.
    task automatic do_txn(input string tag, input int port, input bit wr, input bit sx,
                          input logic [31:0] addr, input logic [3:0] len, input logic [31:0] wdata,
                          input int stall, input logic [31:0] exp_rdata, input int exp_lat,
                          input int pause_at, input int pause_len);
        int          n, k, prog;
        bit          seen, frozen;
        logic [31:0] exp_a;
        logic [39:0] exp_w;
        n = eff_len(len);
        wr_log.delete();
        set_port(port, wr, sx, addr, len, wdata);
        req_en         = NP'(1) << port;
        io_buffer_full = (stall > 0);
        @(posedge clk);
        k    = 0;
        prog = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            frozen = (pause_at >= 0) && (k > pause_at) && (k <= pause_at + pause_len);
            if (!frozen) prog++;
            if (!wr) begin
                exp_a = (prog < n) ? addr + 32'(prog) : 32'h0;
                check($sformatf("%s_mem_a_k%0d", tag, k), mem_a, exp_a);
            end else if (k <= stall) begin
                check($sformatf("%s_stall_wr_k%0d", tag, k), mem_wr, 0);
            end
            if (done != '0) begin
                seen = 1'b1;
                check({tag, "_done_port"}, done, NP'(1) << port);
                check({tag, "_latency"}, k, exp_lat);
                if (!wr) begin
                    check({tag, "_rdata"}, rdata, exp_rdata);
                    last_rdata = exp_rdata;
                end else begin
                    check({tag, "_rdata_hold"}, rdata, last_rdata);
                    check({tag, "_end_wr"}, mem_wr, 0);
                    check({tag, "_wr_count"}, wr_log.size(), n);
                    for (int i = 0; i < n && i < wr_log.size(); i++) begin
                        exp_w = {addr + 32'(i), 8'(wdata >> (8 * i))};
                        check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_w);
                    end
                end
                $display("txn %s port=%0d wr=%0d addr=%08h len=%0d lat=%0d rdata=%08h",
                         tag, port, wr, addr, n, k, rdata);
                req_en = '0;
            end
            io_buffer_full = (k < stall);
            rdy = !((pause_at >= 0) && (k >= pause_at) && (k < pause_at + pause_len));
        end
        if (!seen) begin
            fail({tag, "_timeout"});
            req_en = '0;
        end
        rdy            = 1'b1;
        io_buffer_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_gap"}, done, 0);
    endtask

    initial begin
        int          ndone;
        bit          seen, prev;
        logic [1:0]  dsum;
        logic [31:0] ra, rw;
        logic [3:0]  rl;
        bit          rwr, rsx;
        int          rp, rn;

        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h0100] = 8'h11; rom[16'h0101] = 8'h22; rom[16'h0102] = 8'h33; rom[16'h0103] = 8'h44;
        rom[16'h0104] = 8'h34; rom[16'h0105] = 8'hF2; rom[16'h0200] = 8'h80;
        rom[16'hFFFE] = 8'h01; rom[16'hFFFF] = 8'h02; rom[16'h0000] = 8'h83;

        //          port wr sx addr          len   wdata         stall exp_rdata     lat
        vecs[0] = '{1,   0, 0, 32'h00000100, 4'd4, 32'h0,        0,    32'h44332211, 4};
        vecs[1] = '{1,   0, 1, 32'h00000200, 4'd1, 32'h0,        0,    32'hFFFFFF80, 1};
        vecs[2] = '{1,   0, 0, 32'h00000200, 4'd1, 32'h0,        0,    32'h00000080, 1};
        vecs[3] = '{1,   1, 0, 32'h00030000, 4'd2, 32'h0000BEEF, 3,    32'h00000080, 6};
        vecs[4] = '{0,   0, 1, 32'h00000104, 4'd2, 32'h0,        0,    32'hFFFFF234, 2};
        vecs[5] = '{0,   0, 0, 32'h00000100, 4'd0, 32'h0,        0,    32'h44332211, 4};
        vecs[6] = '{0,   0, 0, 32'h00000102, 4'd7, 32'h0,        0,    32'hF2344433, 4};
        vecs[7] = '{0,   1, 0, 32'h00000500, 4'd4, 32'hDEADBEEF, 0,    32'hF2344433, 5};
        vecs[8] = '{1,   0, 1, 32'hFFFFFFFE, 4'd3, 32'h0,        0,    32'hFF830201, 3};
        vecs[9] = '{1,   1, 0, 32'h00030010, 4'd1, 32'h000000A5, 0,    32'hFF830201, 2};

        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        req_en = '0; req_wr = '0; req_sext = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", done, 0);
        check("reset_mem_wr", mem_wr, 0);
        check("reset_mem_a", mem_a, 0);
        check("reset_mem_dout", mem_dout, 0);
        check("reset_rdata", rdata, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            do_txn($sformatf("vec%0d", v), vecs[v].port, vecs[v].wr, vecs[v].sext, vecs[v].addr,
                   vecs[v].len, vecs[v].wdata, vecs[v].stall, vecs[v].exp_rdata, vecs[v].exp_lat, -1, 0);

        // rdy held low for 5 cycles after the first byte: mem_a must freeze on 0x101.
        do_txn("rdy_pause", 1, 0, 0, 32'h100, 4'd4, 32'h0, 0, 32'h44332211, 9, 1, 5);

        // Killable load aborted after two bytes; the waiting port 0 is served next.
        set_port(1, 0, 0, 32'h100, 4'd4, 32'h0);
        req_en = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_port(0, 0, 0, 32'h104, 4'd2, 32'h0);
        rollback = 1'b1;
        req_en   = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rollback = 1'b0;
        check("abort_done", done, 0);
        check("abort_mem_a", mem_a, 0);
        check("abort_rdata", rdata, last_rdata);
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done != '0) begin
                seen = 1'b1;
                check("abort_next_port", done, 2'b01);
                check("abort_next_rdata", rdata, model_load(32'h104, 2, 1'b0));
                last_rdata = model_load(32'h104, 2, 1'b0);
                $display("txn abort_next port=0 rdata=%08h", rdata);
            end
        end
        if (!seen) fail("abort_next");
        req_en = '0;
        @(posedge clk);
        @(negedge clk);
        check("abort_gap", done, 0);

        rollback = 1'b1;
        do_txn("rb_port0_load", 0, 0, 0, 32'h100, 4'd4, 32'h0, 0, 32'h44332211, 4, -1, 0);
        do_txn("rb_port1_store", 1, 1, 0, 32'h700, 4'd3, 32'h00A1B2C3, 0, 32'h0, 4, -1, 0);
        rollback = 1'b0;

        // Reset in the middle of a store: everything returns to zero and no done follows.
        set_port(1, 1, 0, 32'h600, 4'd4, 32'h11223344);
        req_en = 2'b10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("prereset_wr", mem_wr, 1);
        rst    = 1'b0;
        req_en = '0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_done", done, 0);
        check("midrst_mem_wr", mem_wr, 0);
        check("midrst_mem_a", mem_a, 0);
        check("midrst_mem_dout", mem_dout, 0);
        check("midrst_rdata", rdata, 0);
        rst        = 1'b1;
        last_rdata = '0;
        dsum       = '0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            dsum = dsum | done | {1'b0, mem_wr};
        end
        check("midrst_quiet", dsum, 0);

        // Both ports requesting continuously from rr_ptr=0: grants alternate 0,1,0,1.
        set_port(0, 0, 0, 32'h200, 4'd1, 32'h0);
        set_port(1, 0, 0, 32'h101, 4'd1, 32'h0);
        req_en = 2'b11;
        ndone  = 0;
        prev   = 1'b0;
        for (int c = 0; c < 30 && ndone < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (prev) begin
                check($sformatf("rr_gap%0d", ndone), done, 0);
                prev = 1'b0;
            end else if (done != '0) begin
                check($sformatf("rr_order%0d", ndone), done, (ndone % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("rr_rdata%0d", ndone), rdata, (ndone % 2 == 0) ? 32'h80 : 32'h22);
                $display("txn rr%0d done=%b rdata=%08h", ndone, done, rdata);
                ndone++;
                prev = 1'b1;
            end
        end
        if (ndone < 4) fail("rr_alternate");
        req_en     = '0;
        last_rdata = 32'h22;
        @(posedge clk);
        @(negedge clk);
        check("rr_end_gap", done, 0);

        for (int t = 0; t < 80; t++) begin
            rp  = int'($urandom_range(0, 1));
            rwr = 1'($urandom);
            rsx = 1'($urandom);
            ra  = $urandom;
            rl  = 4'($urandom_range(0, 6));
            rw  = $urandom;
            rn  = eff_len(rl);
            do_txn($sformatf("rnd%0d", t), rp, rwr, rsx, ra, rl, rw, 0,
                   rwr ? 32'h0 : model_load(ra, rn, rsx), rwr ? rn + 1 : rn, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
